// File: rtl/rr_select_sequencer.sv
// Round-robin arbiter/sequencer driving a shared one-hot select decoder.
// A grant is held until done, withdrawal, or a MAX_HOLD forced release.
module rr_select_sequencer #(
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 15,
  localparam int N_REQ   = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_d;
  logic             timeout_d;
  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  function automatic logic [N_REQ-1:0] decode(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  // Rotating priority search starting just above the last-served index
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_q + IDX_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    last_d    = last_q;
    idx_d     = gnt_idx;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d = GRANT;
          idx_d   = win;
          hold_d  = '0;
        end
      end
      GRANT: begin
        // A withdrawn request is a normal completion, never a timeout
        if (done || !req[gnt_idx]) begin
          state_d = RELEASE;
          last_d  = gnt_idx;
        end else if (hold_q == HOLD_LAST) begin
          state_d   = RELEASE;
          last_d    = gnt_idx;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      gnt_idx   <= idx_d;
      gnt_valid <= (state_d == GRANT);
      gnt       <= (state_d == GRANT) ? decode(idx_d) : '0;
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_select_sequencer.sv
// Directed bench for rr_select_sequencer: reset, rotation, wrap, timeout, edge cases.
module tb_rr_select_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_select_sequencer #(.IDX_W(3), .MAX_HOLD(15)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 8'h00; done = 1'b0; en = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; en = 1'b1; done = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: gnt=%h idx=%0d vld=%b to=%b, need 00/0/0/0",
                 i, gnt, gnt_idx, gnt_valid, timeout);
      end
      step();
    end
    req = 8'h00;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [2:0] exp_idx [3] = '{3'd0, 3'd2, 3'd0};
    int waits;
    do_reset();
    req = 8'b0000_0101;
    for (int n = 0; n < 3; n++) begin
      waits = 0;
      while (!gnt_valid && waits < 6) begin step(); waits++; end
      checks++;
      if (waits !== ((n == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL basic latency g%0d: %0d cycles, need %0d", n, waits, (n == 0) ? 1 : 2);
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (gnt !== (8'h01 << exp_idx[n]) || gnt_idx !== exp_idx[n] || gnt_valid !== 1'b1) begin
          errors++;
          $display("FAIL basic grant g%0d c%0d: gnt=%h idx=%0d, need %h idx %0d",
                   n, c, gnt, gnt_idx, 8'h01 << exp_idx[n], exp_idx[n]);
        end
        if (c < 2) step();
      end
      done = 1'b1;
      step();
      done = 1'b0;
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_idx !== exp_idx[n]) begin
        errors++;
        $display("FAIL basic release g%0d: gnt=%h vld=%b to=%b idx=%0d, need 00/0/0/%0d",
                 n, gnt, gnt_valid, timeout, gnt_idx, exp_idx[n]);
      end
    end
    req = 8'h00;
  endtask

  task automatic test_wrap();
    int waits;
    logic [2:0] e;
    do_reset();
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      e = 3'(n);
      waits = 0;
      while (!gnt_valid && waits < 6) begin step(); waits++; end
      checks++;
      if (gnt !== (8'h01 << e) || gnt_idx !== e) begin
        errors++;
        $display("FAIL wrap g%0d: gnt=%h idx=%0d, need %h idx %0d", n, gnt, gnt_idx, 8'h01 << e, e);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL wrap gap g%0d: gnt=%h vld=%b, need 00/0", n, gnt, gnt_valid);
      end
    end
    req = 8'h00;
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    req = 8'h10;
    step();
    cnt = 0;
    while (gnt_valid && cnt < 40) begin
      checks++;
      if (gnt !== 8'h10 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout hold c%0d: gnt=%h to=%b, need 10/0", cnt, gnt, timeout);
      end
      cnt++;
      step();
    end
    checks++;
    if (cnt !== 15 || timeout !== 1'b1 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL timeout release: held %0d to=%b gnt=%h, need 15/1/00", cnt, timeout, gnt);
    end
    step();
    checks++;
    if (timeout !== 1'b0 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL timeout pulse: to=%b gnt=%h, need 0/00", timeout, gnt);
    end
    step();
    checks++;
    if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin
      errors++;
      $display("FAIL timeout regrant: gnt=%h idx=%0d, need 10 idx 4", gnt, gnt_idx);
    end
    req = 8'h00;
    step();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL withdraw: gnt=%h vld=%b to=%b, need 00/0/0", gnt, gnt_valid, timeout);
    end
    step();
  endtask

  task automatic test_done_last();
    do_reset();
    req = 8'h10;
    step();
    for (int c = 0; c < 14; c++) step();
    checks++;
    if (gnt !== 8'h10) begin
      errors++;
      $display("FAIL lastcyc grant: gnt=%h, need 10", gnt);
    end
    done = 1'b1;
    en = 1'b0;
    step();
    done = 1'b0;
    checks++;
    if (timeout !== 1'b0 || gnt_valid !== 1'b0 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL lastcyc done: to=%b vld=%b gnt=%h, need 0/0/00", timeout, gnt_valid, gnt);
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 1) done = 1'b1;
      step();
      done = 1'b0;
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL en_low c%0d: gnt=%h vld=%b to=%b, need 00/0/0", c, gnt, gnt_valid, timeout);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (gnt !== 8'h10 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL en_high: gnt=%h vld=%b, need 10/1", gnt, gnt_valid);
    end
    en = 1'b0;
    req = 8'h11;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (gnt !== 8'h10 || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL en_drop c%0d: gnt=%h vld=%b, need 10/1", c, gnt, gnt_valid);
      end
    end
    en = 1'b1;
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h08;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    step();
    checks++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL midrst pre: gnt=%h idx=%0d, need 08 idx 3", gnt, gnt_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL midrst async: gnt=%h vld=%b idx=%0d to=%b, need 00/0/0/0",
               gnt, gnt_valid, gnt_idx, timeout);
    end
    req = 8'h88;
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst first: gnt=%h idx=%0d vld=%b, need 08 idx 3", gnt, gnt_idx, gnt_valid);
    end
    req = 8'h00;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_done_last();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
